// File: rtl/ttpu_mem_pkg.sv
// Shared TTPU tile-memory types: geometry, fetch FSM states and the window config check.
package ttpu_mem_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned IMAGE_WIDTH  = 8;
    localparam int unsigned IMAGE_HEIGHT = 8;
    localparam int unsigned NUM_UNITS    = 2;
    localparam int unsigned MAX_KERNEL   = 4;
    localparam int unsigned DEPTH        = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned ADDR_W       = $clog2(DEPTH);
    localparam int unsigned KDIM_W       = $clog2(MAX_KERNEL + 1);

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [KDIM_W-1:0]     kdim_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;

    // A lane window is legal when it stays inside one tile row span and inside the tile.
    function automatic logic cfg_ok(input addr_t base, input kdim_t kr, input kdim_t kc);
        int unsigned b;
        int unsigned r;
        int unsigned c;
        b = 32'(base);
        r = 32'(kr);
        c = 32'(kc);
        if (r == 0 || c == 0 || r > MAX_KERNEL || c > MAX_KERNEL) return 1'b0;
        if ((b % IMAGE_WIDTH) + c > IMAGE_WIDTH) return 1'b0;
        if (b + (r - 1) * IMAGE_WIDTH + c - 1 >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/window_fetch_unit_if.sv
// Handshake, write-port and config bundle between a host/consumer and window_fetch_unit.
interface window_fetch_unit_if;
    import ttpu_mem_pkg::*;

    logic                       start;
    kdim_t                      kernel_rows;
    kdim_t                      kernel_cols;
    addr_t [NUM_UNITS-1:0]      base_addr;
    logic  [NUM_UNITS-1:0]      wr_en;
    addr_t [NUM_UNITS-1:0]      wr_addr;
    data_t [NUM_UNITS-1:0]      wr_data;
    logic                       out_valid;
    logic                       out_ready;
    data_t [NUM_UNITS-1:0]      out_data;
    logic                       out_last;
    logic                       busy;
    logic                       done;
    logic                       cfg_err;

    modport master (
        output start, kernel_rows, kernel_cols, base_addr,
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_data, out_last, busy, done, cfg_err
    );

    modport slave (
        input  start, kernel_rows, kernel_cols, base_addr,
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_data, out_last, busy, done, cfg_err
    );

endinterface

// File: rtl/window_fetch_unit_addr_gen.sv
// Shared row-major window offset generator; o_last_c flags that the current offset is the final element.
module window_addr_gen
    import ttpu_mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_clear,
    input  logic  i_advance,
    input  kdim_t i_kr,
    input  kdim_t i_kc,
    output addr_t o_off,
    output logic  o_last_c
);

    kdim_t r_row;
    kdim_t r_col;
    addr_t r_off;
    logic  w_row_end;

    assign w_row_end = (r_col == i_kc - KDIM_W'(1));
    assign o_last_c  = w_row_end && (r_row == i_kr - KDIM_W'(1));
    assign o_off     = r_off;

    // End of a window row jumps to the same column origin on the next tile row.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_row <= '0;
            r_col <= '0;
            r_off <= '0;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + KDIM_W'(1);
                r_off <= r_off + ADDR_W'(IMAGE_WIDTH) - ADDR_W'(i_kc) + ADDR_W'(1);
            end else begin
                r_col <= r_col + KDIM_W'(1);
                r_off <= r_off + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/window_fetch_unit.sv
// Multi-lane tile memory that streams a KR x KC window per lane with valid/ready backpressure.
module window_fetch_unit
    import ttpu_mem_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    window_fetch_unit_if.slave  io_bus
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    data_t                 r_mem [DEPTH];
    kdim_t                 r_kr;
    kdim_t                 r_kc;
    addr_t [NUM_UNITS-1:0] r_base;
    data_t [NUM_UNITS-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_err;

    logic                  w_idle;
    logic                  w_cfg_ok;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_hs;
    logic                  w_clear;
    logic                  w_last_c;
    addr_t                 w_off;
    kdim_t                 w_kr;
    kdim_t                 w_kc;
    addr_t [NUM_UNITS-1:0] w_base;
    addr_t [NUM_UNITS-1:0] w_rd_addr;

    assign w_idle = (r_state == IDLE);
    assign w_hs   = r_valid && io_bus.out_ready;
    // The first beat is read on the accepting edge, so IDLE uses the live config inputs.
    assign w_kr   = w_idle ? io_bus.kernel_rows : r_kr;
    assign w_kc   = w_idle ? io_bus.kernel_cols : r_kc;

    always_comb begin
        w_cfg_ok = 1'b1;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (!cfg_ok(io_bus.base_addr[i], io_bus.kernel_rows, io_bus.kernel_cols)) begin
                w_cfg_ok = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            w_base[i]    = w_idle ? io_bus.base_addr[i] : r_base[i];
            w_rd_addr[i] = w_base[i] + w_off;
        end
    end

    window_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_issue),
        .i_kr      (w_kr),
        .i_kc      (w_kc),
        .o_off     (w_off),
        .o_last_c  (w_last_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.start && w_cfg_ok) begin
                    w_accept    = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = w_last_c ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (!r_valid || w_hs) begin
                    w_issue = 1'b1;
                    if (w_last_c) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs) w_state_nxt = DONE;
            end
            DONE: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Later lanes overwrite earlier ones on a shared address; reads see pre-write data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (io_bus.wr_en[i]) r_mem[io_bus.wr_addr[i]] <= io_bus.wr_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_kr      <= '0;
            r_kc      <= '0;
            r_base    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_idle && io_bus.start && !w_cfg_ok;
            r_done    <= (r_state == DRAIN) && w_hs;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_kr   <= io_bus.kernel_rows;
                r_kc   <= io_bus.kernel_cols;
                r_base <= io_bus.base_addr;
            end
            if (w_issue) begin
                for (int i = 0; i < int'(NUM_UNITS); i++) begin
                    r_data[i] <= r_mem[w_rd_addr[i]];
                end
                r_valid <= 1'b1;
                r_last  <= w_last_c;
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign io_bus.out_valid = r_valid;
    assign io_bus.out_data  = r_data;
    assign io_bus.out_last  = r_last;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.cfg_err   = r_cfg_err;

endmodule
